time_of_day_counter: RTL and testbench
======================================

Name: time_of_day_counter

Overview:
Timekeeping core of the digital alarm clock. It divides the system clock down to a 1 Hz tick and maintains the current time as BCD hours, minutes and seconds in 24-hour format. Its outputs feed the alarm comparator and the seven-segment display driver. Its inputs come from the debounced button / mode controller.

Parameters:
TICKS_PER_SEC, 10000000, system clock cycles per second. Must be ≥2. Benches use 4.
PRESC_W, $clog2(TICKS_PER_SEC), width of the prescaler counter (derived; do not override).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state
set_mode  input  1  high = time-set mode; timekeeping paused
inc_hour  input  1  single-cycle pulse; increment hours (set_mode only)
inc_min  input  1  single-cycle pulse; increment minutes (set_mode only)
clr_sec  input  1  single-cycle pulse; seconds to 00 (set_mode only)
hours_bcd  output  8  hours, BCD {tens[7:4], units[3:0]}, 00–23
minutes_bcd  output  8  minutes, BCD, 00–59
seconds_bcd  output  8  seconds, BCD, 00–59
sec_tick  output  1  one-cycle pulse when seconds advance
min_tick  output  1  one-cycle pulse when seconds wrap 59→00 in run mode
day_tick  output  1  one-cycle pulse on 23:59:59→00:00:00

Behaviour:
- Reset: clk is the only clock. rst_n low asynchronously clears the prescaler and the time to 00:00:00, and clears all tick outputs to 0. Release is synchronous to the next clk edge. Reset asserted mid-count discards all state.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Run mode (ena=1, set_mode=0):
  - The prescaler counts 0..TICKS_PER_SEC-1.
  - On the edge where prescaler == TICKS_PER_SEC-1:
    - prescaler → 0;
    - seconds advance;
    - sec_tick = 1 for exactly the cycle in which the new seconds value is visible.
  - Seconds 59 → 00 carries +1 into minutes and asserts min_tick in the same cycle as sec_tick.
  - Minutes 59 → 00 carries +1 into hours.
  - Hours 23 → 00 asserts day_tick, coincident with sec_tick and min_tick.
  - The first sec_tick after reset release occurs TICKS_PER_SEC cycles after the first enabled edge.
- BCD arithmetic:
  - Units digit 9 → 0 with tens+1.
  - Seconds/minutes wrap at 59; hours wrap at 23 (23 → 00, not 24).
  - No output ever holds a non-BCD digit or an out-of-range value.
- Set mode (ena=1, set_mode=1):
  - The prescaler is held at 0; seconds do not advance; sec_tick, min_tick and day_tick stay 0.
  - inc_min: minutes +1 mod 60, with no carry into hours.
  - inc_hour: hours +1 mod 24.
  - clr_sec: seconds → 00.
  - Simultaneous pulses all apply in the same cycle, independently.
  - A pulse held high for N cycles increments N times. Edge detection is upstream's job.
- Leaving set mode: the prescaler restarts from 0, so the first sec_tick occurs exactly TICKS_PER_SEC cycles after the first edge with set_mode=0.
- inc_hour, inc_min and clr_sec are ignored while set_mode=0.
- ena=0:
  - prescaler and time hold;
  - all inputs are ignored;
  - tick outputs are 0.
  - When ena returns high, counting resumes from the held prescaler value.
- Entering set mode mid-second discards the partial prescaler count. This is intentional: setting time restarts the second.

Test Plan:
1. Reset, then run with TICKS_PER_SEC=4, ena=1 → sec_tick every 4th cycle. seconds_bcd reads 0x01, then 0x02. No sec_tick in the first 3 cycles.
2. Set mode: pulse inc_hour 23×, inc_min 59×, clr_sec; exit set mode; run 59 s → seconds reach 0x59 at 23:59. The next tick yields 00:00:00 with sec_tick, min_tick and day_tick all high in one cycle.
3. BCD carry: run from 00:00:00 for 10 s → seconds_bcd = 0x10, never 0x0A. Run to 60 s → 00:01:00 with min_tick.
4. Set mode wrap: hours=0x23 plus inc_hour → 0x00. Minutes=0x59 plus inc_min → 0x00 with hours unchanged. Simultaneous inc_hour, inc_min and clr_sec apply together. All three pulses are ignored when set_mode=0.
5. Freeze: drop ena for 10 cycles mid-second → outputs and prescaler hold, no ticks. After re-enable, the remaining prescaler count completes before the next sec_tick.
6. Async reset: assert rst_n low between clock edges at 12:34:56 → all outputs read 0 immediately without a clock edge. After release, the first sec_tick arrives 4 cycles later.

Source files
------------

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour BCD timekeeping core of the alarm clock.
// A prescaler divides clk down to one tick per second. In run mode the tick
// advances hh:mm:ss. In set mode the count is paused and the button pulses
// adjust the time directly.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ena               design enable; low freezes all state, ticks read 0
//   set_mode          high = time-set mode, timekeeping paused
//   inc_hour          per-cycle hours +1 mod 24 (set mode only)
//   inc_min           per-cycle minutes +1 mod 60, no carry (set mode only)
//   clr_sec           per-cycle seconds -> 00 (set mode only)
//   hours_bcd         BCD hours 00-23, registered
//   minutes_bcd       BCD minutes 00-59, registered
//   seconds_bcd       BCD seconds 00-59, registered
//   sec_tick          one-cycle pulse, coincident with the new seconds value
//   min_tick          one-cycle pulse on a seconds wrap 59 -> 00 in run mode
//   day_tick          one-cycle pulse on 23:59:59 -> 00:00:00
module time_of_day_counter #(
  parameter int unsigned TICKS_PER_SEC = 10000000,
  parameter int unsigned PRESC_W       = $clog2(TICKS_PER_SEC)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       clr_sec,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       day_tick
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]         SEC_MAX    = 8'h59;
  localparam logic [7:0]         MIN_MAX    = 8'h59;
  localparam logic [7:0]         HOUR_MAX   = 8'h23;

  // BCD increment that wraps to 00 after max_val; units 9 carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                         input logic [7:0] max_val);
    logic [7:0] res;
    if (val == max_val) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic [7:0]         hours_d;
  logic [7:0]         minutes_d;
  logic [7:0]         seconds_d;
  logic               sec_tick_d;
  logic               min_tick_d;
  logic               day_tick_d;

  // Next-state: prescaler, time digits and tick pulses.
  always_comb begin
    presc_d    = presc_q;
    hours_d    = hours_bcd;
    minutes_d  = minutes_bcd;
    seconds_d  = seconds_bcd;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    day_tick_d = 1'b0;

    if (ena) begin
      if (set_mode) begin
        // Setting time restarts the second; pulses apply independently.
        presc_d = '0;
        if (inc_hour) hours_d   = bcd_inc(hours_bcd, HOUR_MAX);
        if (inc_min)  minutes_d = bcd_inc(minutes_bcd, MIN_MAX);
        if (clr_sec)  seconds_d = 8'h00;
      end else if (presc_q == PRESC_LAST) begin
        presc_d    = '0;
        sec_tick_d = 1'b1;
        seconds_d  = bcd_inc(seconds_bcd, SEC_MAX);
        if (seconds_bcd == SEC_MAX) begin
          min_tick_d = 1'b1;
          minutes_d  = bcd_inc(minutes_bcd, MIN_MAX);
          if (minutes_bcd == MIN_MAX) begin
            hours_d = bcd_inc(hours_bcd, HOUR_MAX);
            if (hours_bcd == HOUR_MAX) day_tick_d = 1'b1;
          end
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      hours_bcd   <= 8'h00;
      minutes_bcd <= 8'h00;
      seconds_bcd <= 8'h00;
      sec_tick    <= 1'b0;
      min_tick    <= 1'b0;
      day_tick    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      hours_bcd   <= hours_d;
      minutes_bcd <= minutes_d;
      seconds_bcd <= seconds_d;
      sec_tick    <= sec_tick_d;
      min_tick    <= min_tick_d;
      day_tick    <= day_tick_d;
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with TICKS_PER_SEC = 4.
module tb_time_of_day_counter;

  localparam int unsigned TPS = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       set_mode;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic [7:0] hours_bcd;
  logic [7:0] minutes_bcd;
  logic [7:0] seconds_bcd;
  logic       sec_tick;
  logic       min_tick;
  logic       day_tick;

  int n_checks = 0;
  int n_errors = 0;
  int bad_bcd  = 0;

  time_of_day_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .set_mode   (set_mode),
    .inc_hour   (inc_hour),
    .inc_min    (inc_min),
    .clr_sec    (clr_sec),
    .hours_bcd  (hours_bcd),
    .minutes_bcd(minutes_bcd),
    .seconds_bcd(seconds_bcd),
    .sec_tick   (sec_tick),
    .min_tick   (min_tick),
    .day_tick   (day_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags any digit outside BCD or any out-of-range time value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (seconds_bcd[3:0] > 4'd9 || seconds_bcd[7:4] > 4'd5 ||
          minutes_bcd[3:0] > 4'd9 || minutes_bcd[7:4] > 4'd5 ||
          hours_bcd[3:0]   > 4'd9 || hours_bcd > 8'h23)
        bad_bcd++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {hours_bcd, minutes_bcd, seconds_bcd}, 32'(exp));
  endtask

  task automatic check_ticks(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, sec_tick, min_tick, day_tick}, 32'(exp));
  endtask

  int tick_cnt;

  initial begin
    rst_n = 1'b0; ena = 1'b0; set_mode = 1'b0;
    inc_hour = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
    step(2);
    check_time("reset_time", 24'h000000);
    check_ticks("reset_ticks", 3'b000);

    // Run mode: tick on every 4th enabled edge.
    rst_n = 1'b1; ena = 1'b1;
    step(1); check_ticks("run_c1", 3'b000);
    step(1); check_ticks("run_c2", 3'b000);
    step(1); check_ticks("run_c3", 3'b000);
    step(1); check_ticks("run_c4", 3'b100);
    check("run_sec1", 32'(seconds_bcd), 32'h01);
    step(1); check_ticks("run_c5", 3'b000);
    step(3); check_ticks("run_c8", 3'b100);
    check("run_sec2", 32'(seconds_bcd), 32'h02);

    // BCD carry 09 -> 10 and minute carry.
    step(8 * TPS);
    check("bcd_sec10", 32'(seconds_bcd), 32'h10);
    step(50 * TPS);
    check_time("min_carry_time", 24'h000100);
    check_ticks("min_carry_ticks", 3'b110);
    step(1); check_ticks("min_carry_after", 3'b000);

    // Set 23:59:00 (entered mid-second), then run to the day wrap.
    set_mode = 1'b1;
    inc_hour = 1'b1; step(23); inc_hour = 1'b0;
    check("set_hour23", 32'(hours_bcd), 32'h23);
    inc_min = 1'b1; step(58); inc_min = 1'b0;
    check("set_min59", 32'(minutes_bcd), 32'h59);
    check_ticks("set_no_ticks", 3'b000);
    clr_sec = 1'b1; step(1); clr_sec = 1'b0;
    check_time("set_2359", 24'h235900);
    set_mode = 1'b0;
    step(3); check_ticks("exit_set_c3", 3'b000);
    step(1); check_ticks("exit_set_c4", 3'b100);
    check("exit_set_sec", 32'(seconds_bcd), 32'h01);
    step(58 * TPS);
    check_time("pre_day_wrap", 24'h235959);
    check_ticks("pre_day_ticks", 3'b100);
    step(TPS);
    check_time("day_wrap_time", 24'h000000);
    check_ticks("day_wrap_ticks", 3'b111);
    step(1); check_ticks("day_wrap_after", 3'b000);

    // Set mode wraps and simultaneous pulses; entered at prescaler 2.
    step(3 + 5 * TPS + 2);
    check("pre_set_sec", 32'(seconds_bcd), 32'h06);
    set_mode = 1'b1;
    inc_hour = 1'b1; step(23); inc_hour = 1'b0;
    inc_min = 1'b1; step(59); inc_min = 1'b0;
    check_time("set_2359_06", 24'h235906);
    inc_min = 1'b1; step(1); inc_min = 1'b0;
    check_time("min_wrap_no_carry", 24'h230006);
    inc_hour = 1'b1; step(1); inc_hour = 1'b0;
    check_time("hour_wrap", 24'h000006);
    inc_hour = 1'b1; inc_min = 1'b1; clr_sec = 1'b1; step(1);
    check_time("simul_pulses", 24'h010100);
    set_mode = 1'b0; step(1);
    inc_hour = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
    check_time("pulses_ignored_run", 24'h010100);
    step(2); check_ticks("restart_c3", 3'b000);
    step(1); check_ticks("restart_c4", 3'b100);
    check_time("restart_time", 24'h010101);

    // Freeze mid-second; inputs ignored while disabled.
    step(2);
    ena = 1'b0; set_mode = 1'b1; inc_hour = 1'b1; clr_sec = 1'b1;
    tick_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sec_tick || min_tick || day_tick) tick_cnt++;
    end
    check("freeze_ticks", 32'(tick_cnt), 32'd0);
    check_time("freeze_time", 24'h010101);
    set_mode = 1'b0; inc_hour = 1'b0; clr_sec = 1'b0; ena = 1'b1;
    step(1); check_ticks("resume_c1", 3'b000);
    step(1); check_ticks("resume_c2", 3'b100);
    check_time("resume_time", 24'h010102);

    // Reach 12:34:56 then reset between edges.
    set_mode = 1'b1;
    inc_hour = 1'b1; step(11); inc_hour = 1'b0;
    inc_min = 1'b1; step(33); inc_min = 1'b0;
    clr_sec = 1'b1; step(1); clr_sec = 1'b0;
    set_mode = 1'b0;
    step(56 * TPS);
    check_time("at_123456", 24'h123456);
    check_ticks("at_123456_ticks", 3'b100);
    #2 rst_n = 1'b0;
    #1;
    check_time("async_rst_time", 24'h000000);
    check_ticks("async_rst_ticks", 3'b000);
    step(2);
    rst_n = 1'b1;
    step(3); check_ticks("post_rst_c3", 3'b000);
    step(1); check_ticks("post_rst_c4", 3'b100);
    check_time("post_rst_time", 24'h000001);

    check("bcd_valid", 32'(bad_bcd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
